// File: rtl/seq_n_pkg.sv
// seq_n_pkg: opcode constants, FSM states and instruction field layout shared
// by the seq_n sequencer and its call stack.
package seq_n_pkg;

   localparam int OPC_W = 4;
   localparam int FA_W  = 8;
   localparam int IDX_W = 5;
   localparam int BIT_W = 3;

   typedef enum logic [3:0] {
      OP_NOP   = 4'h0,
      OP_OUT   = 4'h1,
      OP_JMP   = 4'h2,
      OP_WAITS = 4'h3,
      OP_WAITC = 4'h4,
      OP_JBS   = 4'h5,
      OP_CALL  = 4'h6,
      OP_RET   = 4'h7,
      OP_LDC   = 4'h8,
      OP_DJNZ  = 4'h9,
      OP_DELAY = 4'hA,
      OP_HALT  = 4'hF
   } opcode_e;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_DLY  = 2'd1,
      ST_HALT = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   // field_a = {idx[4:0], bit[2:0]}
   function automatic logic [IDX_W-1:0] fa_idx(input logic [FA_W-1:0] fa);
      return fa[FA_W-1 -: IDX_W];
   endfunction

   function automatic logic [BIT_W-1:0] fa_bit(input logic [FA_W-1:0] fa);
      return fa[BIT_W-1:0];
   endfunction

endpackage

// File: rtl/seq_n_stack.sv
// seq_n_stack: DEPTH x WIDTH LIFO holding return addresses; pushes when full
// and pops when empty are ignored (the sequencer treats them as faults).
module seq_n_stack
   import seq_n_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_top,
   output logic             o_full,
   output logic             o_empty
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CNT_W-1:0] r_cnt;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_cnt == CNT_W'(DEPTH));
   assign o_empty   = (r_cnt == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Top-of-stack read as an AND-OR mux over the occupied entry.
   always_comb begin
      o_top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         o_top = o_top | ({WIDTH{r_cnt == CNT_W'(i + 1)}} & r_mem[i]);
      end
   end

   // Entry storage and occupancy count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_do_push && (r_cnt == CNT_W'(i))) begin
               r_mem[i] <= i_data;
            end
         end
         if (w_do_push) begin
            r_cnt <= r_cnt + CNT_W'(1'b1);
         end else if (w_do_pop) begin
            r_cnt <= r_cnt - CNT_W'(1'b1);
         end
      end
   end

endmodule

// File: rtl/seq_n.sv
// seq_n: ROM-driven sequencer with call stack, loop counter, timed delay and
// halt/fault states. Optional stall watchdog is enabled by SEQ_N_WATCHDOG_EN.
module seq_n
   import seq_n_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 12,
   parameter int NUM_IREGS   = 4,
   parameter int IREG_WIDTH  = 8,
   parameter int NUM_OREGS   = 8,
   parameter int STACK_DEPTH = 4
`ifdef SEQ_N_WATCHDOG_EN
   ,
   parameter int WATCHDOG_CYCLES = 1024
`endif
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [OPC_W+FA_W+DATA_WIDTH-1:0]  inst,
   input  logic                              inst_en,
   input  logic [NUM_IREGS*IREG_WIDTH-1:0]   ireg,
   output logic [ADDR_WIDTH-1:0]             next,
   output logic [DATA_WIDTH-1:0]             oreg,
   output logic [NUM_OREGS-1:0]              oreg_wen,
   output logic                              halted,
   output logic                              error
);

   localparam int INST_W = OPC_W + FA_W + DATA_WIDTH;

   state_e                  r_state;
   state_e                  w_state_n;
   logic [ADDR_WIDTH-1:0]   r_next;
   logic [ADDR_WIDTH-1:0]   w_next_n;
   logic [DATA_WIDTH-1:0]   r_oreg;
   logic [DATA_WIDTH-1:0]   w_oreg_n;
   logic [NUM_OREGS-1:0]    r_wen;
   logic [NUM_OREGS-1:0]    w_wen_n;
   logic [DATA_WIDTH-1:0]   r_cnt;
   logic [DATA_WIDTH-1:0]   w_cnt_n;
   logic [DATA_WIDTH-1:0]   r_dly;
   logic [DATA_WIDTH-1:0]   w_dly_n;
   logic                    r_halted;
   logic                    w_halted_n;
   logic                    r_error;
   logic                    w_error_n;

   logic [OPC_W-1:0]        w_opc;
   logic [FA_W-1:0]         w_fa;
   logic [DATA_WIDTH-1:0]   w_fb;
   logic [IDX_W-1:0]        w_idx;
   logic [BIT_W-1:0]        w_bit;
   logic                    w_bit_bad;
   logic                    w_chan_bad;
   logic                    w_bit_val;
   logic                    w_wait_go;
   logic                    w_fault;
   logic [NUM_IREGS*IREG_WIDTH-1:0] w_ireg_sh;
   logic [NUM_OREGS-1:0]    w_wen_hot;
   logic [ADDR_WIDTH-1:0]   w_inc;
   logic [ADDR_WIDTH-1:0]   w_target;
   logic                    w_push;
   logic                    w_pop;
   logic [ADDR_WIDTH-1:0]   w_top;
   logic                    w_full;
   logic                    w_empty;

   assign w_opc      = inst[INST_W-1 -: OPC_W];
   assign w_fa       = inst[DATA_WIDTH +: FA_W];
   assign w_fb       = inst[DATA_WIDTH-1:0];
   assign w_idx      = fa_idx(w_fa);
   assign w_bit      = fa_bit(w_fa);
   assign w_bit_bad  = (int'(w_idx) >= NUM_IREGS) || (int'(w_bit) >= IREG_WIDTH);
   assign w_chan_bad = (int'(w_fa) >= NUM_OREGS);
   // Out-of-range selects read a neighbouring bit, but those are faults anyway.
   assign w_ireg_sh  = ireg >> (int'(w_idx) * IREG_WIDTH + int'(w_bit));
   assign w_bit_val  = w_ireg_sh[0];
   assign w_wait_go  = (w_opc == OP_WAITS) ? w_bit_val : ~w_bit_val;
   assign w_wen_hot  = NUM_OREGS'(1'b1) << w_fa;
   assign w_inc      = r_next + ADDR_WIDTH'(1'b1);
   assign w_target   = w_fb[ADDR_WIDTH-1:0];

`ifdef SEQ_N_WATCHDOG_EN
   localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
   logic [WD_W-1:0] r_wd;
   logic [WD_W-1:0] w_wd_n;
   logic            w_wd_trip;
   assign w_wd_trip = (r_wd == WD_W'(WATCHDOG_CYCLES - 1));
`endif

   seq_n_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (ADDR_WIDTH)
   ) u_stack (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_inc),
      .o_top   (w_top),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Fault detection for the instruction currently presented in RUN.
   always_comb begin
      w_fault = 1'b0;
      case (opcode_e'(w_opc))
         OP_NOP, OP_JMP, OP_LDC, OP_DJNZ, OP_DELAY, OP_HALT: w_fault = 1'b0;
         OP_OUT:             w_fault = w_chan_bad;
`ifdef SEQ_N_WATCHDOG_EN
         OP_WAITS, OP_WAITC: w_fault = w_bit_bad || (!w_wait_go && w_wd_trip);
`else
         OP_WAITS, OP_WAITC: w_fault = w_bit_bad;
`endif
         OP_JBS:             w_fault = w_bit_bad;
         OP_CALL:            w_fault = w_full;
         OP_RET:             w_fault = w_empty;
         default:            w_fault = 1'b1;
      endcase
   end

   // Next-state and execute logic; a faulting instruction leaves no side effects.
   always_comb begin
      w_state_n  = r_state;
      w_next_n   = r_next;
      w_oreg_n   = r_oreg;
      w_wen_n    = '0;
      w_cnt_n    = r_cnt;
      w_dly_n    = r_dly;
      w_halted_n = r_halted;
      w_error_n  = r_error;
      w_push     = 1'b0;
      w_pop      = 1'b0;
`ifdef SEQ_N_WATCHDOG_EN
      w_wd_n     = r_wd;
`endif
      if (inst_en) begin
         case (r_state)
            ST_RUN: begin
               if (w_fault) begin
                  w_state_n = ST_ERR;
                  w_error_n = 1'b1;
               end else begin
`ifdef SEQ_N_WATCHDOG_EN
                  w_wd_n = '0;
`endif
                  case (opcode_e'(w_opc))
                     OP_NOP: w_next_n = w_inc;
                     OP_OUT: begin
                        w_oreg_n = w_fb;
                        w_wen_n  = w_wen_hot;
                        w_next_n = w_inc;
                     end
                     OP_JMP: w_next_n = w_target;
                     OP_WAITS, OP_WAITC: begin
                        if (w_wait_go) begin
                           w_next_n = w_inc;
                        end else begin
                           w_next_n = r_next;
`ifdef SEQ_N_WATCHDOG_EN
                           w_wd_n   = r_wd + WD_W'(1'b1);
`endif
                        end
                     end
                     OP_JBS: w_next_n = w_bit_val ? w_target : w_inc;
                     OP_CALL: begin
                        w_push   = 1'b1;
                        w_next_n = w_target;
                     end
                     OP_RET: begin
                        w_pop    = 1'b1;
                        w_next_n = w_top;
                     end
                     OP_LDC: begin
                        w_cnt_n  = w_fb;
                        w_next_n = w_inc;
                     end
                     OP_DJNZ: begin
                        if (r_cnt != '0) begin
                           w_cnt_n  = r_cnt - DATA_WIDTH'(1'b1);
                           w_next_n = w_target;
                        end else begin
                           w_next_n = w_inc;
                        end
                     end
                     // The DELAY edge itself is the first occupied cycle.
                     OP_DELAY: begin
                        if (w_fb == '0) begin
                           w_next_n = w_inc;
                        end else begin
                           w_dly_n   = w_fb - DATA_WIDTH'(1'b1);
                           w_state_n = ST_DLY;
                        end
                     end
                     OP_HALT: begin
                        w_state_n  = ST_HALT;
                        w_halted_n = 1'b1;
                     end
                     default: begin
                        w_state_n = ST_ERR;
                        w_error_n = 1'b1;
                     end
                  endcase
               end
            end
            ST_DLY: begin
               if (r_dly == '0) begin
                  w_next_n  = w_inc;
                  w_state_n = ST_RUN;
               end else begin
                  w_dly_n = r_dly - DATA_WIDTH'(1'b1);
               end
            end
            ST_HALT, ST_ERR: w_wen_n = '0;
            default: begin
               w_state_n = ST_ERR;
               w_error_n = 1'b1;
            end
         endcase
      end else begin
         w_wen_n = '0;
      end
   end

   // Architectural state and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= ST_RUN;
         r_next   <= '0;
         r_oreg   <= '0;
         r_wen    <= '0;
         r_cnt    <= '0;
         r_dly    <= '0;
         r_halted <= 1'b0;
         r_error  <= 1'b0;
`ifdef SEQ_N_WATCHDOG_EN
         r_wd     <= '0;
`endif
      end else begin
         r_state  <= w_state_n;
         r_next   <= w_next_n;
         r_oreg   <= w_oreg_n;
         r_wen    <= w_wen_n;
         r_cnt    <= w_cnt_n;
         r_dly    <= w_dly_n;
         r_halted <= w_halted_n;
         r_error  <= w_error_n;
`ifdef SEQ_N_WATCHDOG_EN
         r_wd     <= w_wd_n;
`endif
      end
   end

   assign next     = r_next;
   assign oreg     = r_oreg;
   assign oreg_wen = r_wen;
   assign halted   = r_halted;
   assign error    = r_error;

endmodule
